// File: rtl/reg_bank_arbiter_if.sv
// Bundles the requester-side and bank-side signals of reg_bank_arbiter.
//   req/we/lock : per-requester request, write enable and grant-lock request
//   addr/wdata  : flattened per-requester address and write data
//   gnt         : one-hot combinational grant
//   rdata       : registered read data
//   rd_valid    : one-hot registered owner of rdata
//   locked      : registered, high while the arbiter is in its locked state
// master = client side, slave = arbiter side.
interface reg_bank_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 3
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [DATA_W-1:0]         rdata;
    logic [NUM_REQ-1:0]        rd_valid;
    logic                      locked;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rdata, rd_valid, locked
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rdata, rd_valid, locked
    );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter owning a DEPTH x DATA_W flip-flop register bank shared by
// NUM_REQ requesters. One access (read or write) happens per clock. A winning
// requester that asserts lock keeps the grant for up to MAX_LOCK consecutive
// accesses.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : reg_bank_arbiter_if slave modport (requests in, grant/read data out)
module reg_bank_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic               clk,
    input  logic               reset,
    reg_bank_arbiter_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned PtrW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW  = $clog2(MAX_LOCK + 1);

    typedef enum logic [0:0] {
        StArb,
        StLocked
    } state_e;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    state_e             state_q, state_d;
    logic [PtrW-1:0]    ptr_q, ptr_d;
    logic [PtrW-1:0]    owner_q, owner_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]  rdata_q;
    logic [NUM_REQ-1:0] rd_valid_q;
    logic               locked_q;

    logic               found;
    logic [PtrW-1:0]    winner;
    logic [NUM_REQ-1:0] gnt;
    logic               acc;
    logic [PtrW-1:0]    sel;
    logic [ADDR_W-1:0]  acc_addr;
    logic [DATA_W-1:0]  acc_wdata;
    logic               acc_we;

    // Rotating priority scan starting at ptr_q.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % int'(NUM_REQ);
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = PtrW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        gnt     = '0;
        sel     = winner;
        if (!reset) begin
            unique case (state_q)
                StArb: begin
                    if (found) begin
                        gnt[winner] = 1'b1;
                        ptr_d = (int'(winner) == int'(NUM_REQ) - 1) ? '0 : winner + 1'b1;
                        // With MAX_LOCK == 1 a lock could never grant a second access,
                        // so locking degenerates to plain arbitration.
                        if (bus.lock[winner] && (MAX_LOCK > 1)) begin
                            state_d = StLocked;
                            owner_d = winner;
                            cnt_d   = CntW'(1);
                        end
                    end
                end
                StLocked: begin
                    sel = owner_q;
                    if (!bus.req[owner_q]) begin
                        state_d = StArb;
                    end else begin
                        gnt[owner_q] = 1'b1;
                        // cnt_q counts accesses already made; this one is cnt_q + 1.
                        if (!bus.lock[owner_q] || (int'(cnt_q) + 1 >= int'(MAX_LOCK))) begin
                            state_d = StArb;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = StArb;
            endcase
        end
    end

    assign acc       = |gnt;
    assign acc_addr  = bus.addr[sel*ADDR_W +: ADDR_W];
    assign acc_wdata = bus.wdata[sel*DATA_W +: DATA_W];
    assign acc_we    = bus.we[sel];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            state_q    <= StArb;
            ptr_q      <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            rd_valid_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            locked_q   <= (state_d == StLocked);
            rd_valid_q <= '0;
            if (acc && acc_we) begin
                mem_q[acc_addr] <= acc_wdata;
            end
            if (acc && !acc_we) begin
                rdata_q    <= mem_q[acc_addr];
                rd_valid_q <= gnt;
            end
        end
    end

    assign bus.gnt      = gnt;
    assign bus.rdata    = rdata_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.locked   = locked_q;
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed self-checking bench for reg_bank_arbiter (default parameters).
module tb_reg_bank_arbiter;
    logic clk;
    logic reset;
    int   total;
    int   passed;

    reg_bank_arbiter_if #(.NUM_REQ(4), .DATA_W(8), .ADDR_W(3)) bus ();

    reg_bank_arbiter #(
        .NUM_REQ (4),
        .DATA_W  (8),
        .ADDR_W  (3),
        .MAX_LOCK(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drv(input int i, input logic r, input logic w, input logic l,
                       input logic [2:0] a, input logic [7:0] d);
        bus.req[i]           = r;
        bus.we[i]            = w;
        bus.lock[i]          = l;
        bus.addr[i*3 +: 3]   = a;
        bus.wdata[i*8 +: 8]  = d;
    endtask

    task automatic clr();
        bus.req   = '0;
        bus.we    = '0;
        bus.lock  = '0;
        bus.addr  = '0;
        bus.wdata = '0;
    endtask

    // Check combinational grant plus registered outputs from the previous edge.
    task automatic look(input string tag, input logic [3:0] g, input logic [3:0] rv,
                        input logic [7:0] rd, input logic lk);
        #1;
        chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
        chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(rv));
        chk({tag, ".rdata"}, 32'(bus.rdata), 32'(rd));
        chk({tag, ".locked"}, 32'(bus.locked), 32'(lk));
    endtask

    initial begin
        total  = 0;
        passed = 0;
        reset  = 1'b1;
        clr();

        // Reset: grant suppressed even with all requesters active.
        @(negedge clk);
        bus.req = 4'b1111;
        #1;
        chk("rst.gnt", 32'(bus.gnt), 32'h0);
        @(negedge clk);
        look("rst", 4'b0000, 4'b0000, 8'h00, 1'b0);

        // Round-robin reads of all four requesters.
        @(negedge clk); reset = 1'b0; look("rr0", 4'b0001, 4'b0000, 8'h00, 1'b0);
        @(negedge clk); look("rr1", 4'b0010, 4'b0001, 8'h00, 1'b0);
        @(negedge clk); look("rr2", 4'b0100, 4'b0010, 8'h00, 1'b0);
        @(negedge clk); look("rr3", 4'b1000, 4'b0100, 8'h00, 1'b0);
        @(negedge clk); clr(); look("rr4", 4'b0000, 4'b1000, 8'h00, 1'b0);

        // Requester 2 writes A5 to addr 3; requester 0 reads it back. ptr: 0 -> 3 -> 1.
        @(negedge clk); clr(); drv(2, 1, 1, 0, 3'd3, 8'hA5);
        look("wr2", 4'b0100, 4'b0000, 8'h00, 1'b0);
        @(negedge clk); clr(); drv(0, 1, 0, 0, 3'd3, 8'h00);
        look("rd0", 4'b0001, 4'b0000, 8'h00, 1'b0);
        @(negedge clk); clr(); look("rd0r", 4'b0000, 4'b0001, 8'hA5, 1'b0);

        // Full lock: requester 1 holds four accesses, then requester 3. ptr=1.
        @(negedge clk); clr(); drv(1, 1, 0, 1, 3'd0, 8'h00); drv(3, 1, 0, 0, 3'd3, 8'h00);
        look("lk0", 4'b0010, 4'b0000, 8'hA5, 1'b0);
        @(negedge clk); look("lk1", 4'b0010, 4'b0010, 8'h00, 1'b1);
        @(negedge clk); look("lk2", 4'b0010, 4'b0010, 8'h00, 1'b1);
        @(negedge clk); look("lk3", 4'b0010, 4'b0010, 8'h00, 1'b1);
        @(negedge clk); look("lk4", 4'b1000, 4'b0010, 8'h00, 1'b0);
        @(negedge clk); clr(); look("lk5", 4'b0000, 4'b1000, 8'hA5, 1'b0);

        // Early unlock after two locked cycles. ptr=0.
        @(negedge clk); clr(); drv(1, 1, 0, 1, 3'd0, 8'h00); drv(3, 1, 0, 0, 3'd0, 8'h00);
        look("ul0", 4'b0010, 4'b0000, 8'hA5, 1'b0);
        @(negedge clk); look("ul1", 4'b0010, 4'b0010, 8'h00, 1'b1);
        @(negedge clk); bus.lock[1] = 1'b0; look("ul2", 4'b0010, 4'b0010, 8'h00, 1'b1);
        @(negedge clk); look("ul3", 4'b1000, 4'b0010, 8'h00, 1'b0);
        @(negedge clk); clr(); look("ul4", 4'b0000, 4'b1000, 8'h00, 1'b0);

        // Lone requester 0: repeated grants, read-after-write in consecutive cycles.
        @(negedge clk); clr(); drv(0, 1, 1, 0, 3'd5, 8'h5A);
        look("s0", 4'b0001, 4'b0000, 8'h00, 1'b0);
        @(negedge clk); drv(0, 1, 0, 0, 3'd5, 8'h00);
        look("s1", 4'b0001, 4'b0000, 8'h00, 1'b0);
        @(negedge clk); look("s2", 4'b0001, 4'b0001, 8'h5A, 1'b0);
        @(negedge clk); drv(0, 1, 0, 0, 3'd3, 8'h00);
        look("s3", 4'b0001, 4'b0001, 8'h5A, 1'b0);
        @(negedge clk); clr(); look("s4", 4'b0000, 4'b0001, 8'hA5, 1'b0);
        @(negedge clk); look("s5", 4'b0000, 4'b0000, 8'hA5, 1'b0);

        // Reset mid-lock with a pending write of 3C to addr 6. ptr=1.
        @(negedge clk); clr(); drv(2, 1, 0, 1, 3'd5, 8'h00);
        look("rl0", 4'b0100, 4'b0000, 8'hA5, 1'b0);
        @(negedge clk); look("rl1", 4'b0100, 4'b0100, 8'h5A, 1'b1);
        @(negedge clk); drv(2, 1, 1, 1, 3'd6, 8'h3C); reset = 1'b1;
        look("rl2", 4'b0000, 4'b0100, 8'h5A, 1'b1);
        @(negedge clk); reset = 1'b0; clr();
        look("rl3", 4'b0000, 4'b0000, 8'h00, 1'b0);
        // ptr back at 0: requester 1 beats requester 3; addr 6 must still be 0.
        @(negedge clk); drv(1, 1, 0, 0, 3'd6, 8'h00); drv(3, 1, 0, 0, 3'd6, 8'h00);
        look("rl4", 4'b0010, 4'b0000, 8'h00, 1'b0);
        // Requester 3 reads addr 3, which reset must have cleared from A5.
        @(negedge clk); clr(); drv(3, 1, 0, 0, 3'd3, 8'h00);
        look("rl5", 4'b1000, 4'b0010, 8'h00, 1'b0);
        @(negedge clk); clr(); look("rl6", 4'b0000, 4'b1000, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
